// File: rtl/serial_to_parallel_rx.sv
// Serial RX front end: MSB-first deserializer with COM-symbol byte alignment and lock detection.
// Optional build macro RX_LOSS_DET_EN: an off-boundary COM while locked drops lock and realigns on it.
module serial_to_parallel_rx #(
    parameter logic [7:0]  COM       = 8'hBC,
    parameter int unsigned COM_COUNT = 4
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned BIT_W  = 3;
    localparam int unsigned COMC_W = 4;

    typedef enum logic [1:0] {
        ALIGN  = 2'd0,
        COUNT  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [BYTE_W-1:0]   r_sr;
    logic [BYTE_W-1:0]   w_nxt;
    logic [BIT_W-1:0]    r_bit_cnt;
    logic [BIT_W-1:0]    w_bit_cnt_nxt;
    logic [COMC_W-1:0]   r_com_cnt;
    logic [COMC_W-1:0]   w_com_cnt_nxt;
    logic [COMC_W-1:0]   w_com_inc;
    logic [BYTE_W-1:0]   r_data;
    logic [BYTE_W-1:0]   w_data_nxt;
    logic                r_valid;
    logic                w_valid_nxt;
    logic                r_active;
    logic                w_active_nxt;
    logic                w_boundary;
    logic                w_is_com;
    logic                w_lock_hit;

    // All decisions look at the window including the bit sampled this edge
    assign w_nxt      = {r_sr[BYTE_W-2:0], data_in};
    assign w_boundary = (r_bit_cnt == BIT_W'(7));
    assign w_is_com   = (w_nxt == COM);
    assign w_com_inc  = r_com_cnt + COMC_W'(1);
    assign w_lock_hit = (32'(w_com_inc) >= COM_COUNT);

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state   <= ALIGN;
            r_sr      <= '0;
            r_bit_cnt <= '0;
            r_com_cnt <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_active  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sr      <= w_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_com_cnt <= w_com_cnt_nxt;
            r_data    <= w_data_nxt;
            r_valid   <= w_valid_nxt;
            r_active  <= w_active_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
        w_com_cnt_nxt = r_com_cnt;
        w_data_nxt    = r_data;
        w_valid_nxt   = 1'b0;
        w_active_nxt  = r_active;

        unique case (r_state)
            ALIGN: begin
                // Sliding search: a COM at any bit offset defines the byte boundary
                if (w_is_com) begin
                    w_bit_cnt_nxt = '0;
                    w_com_cnt_nxt = COMC_W'(1);
                    if (COM_COUNT <= 1) begin
                        w_state_nxt  = ACTIVE;
                        w_active_nxt = 1'b1;
                    end else begin
                        w_state_nxt = COUNT;
                    end
                end
            end
            COUNT: begin
                if (w_boundary) begin
                    if (w_is_com) begin
                        w_com_cnt_nxt = w_com_inc;
                        if (w_lock_hit) begin
                            w_state_nxt  = ACTIVE;
                            w_active_nxt = 1'b1;
                        end
                    end else begin
                        w_state_nxt   = ALIGN;
                        w_com_cnt_nxt = '0;
                    end
                end
            end
            ACTIVE: begin
                if (w_boundary) begin
                    w_data_nxt  = w_nxt;
                    w_valid_nxt = !w_is_com;
                end
`ifdef RX_LOSS_DET_EN
                else if (w_is_com) begin
                    // Misaligned COM: adopt it as the new boundary and re-qualify lock
                    w_active_nxt  = 1'b0;
                    w_bit_cnt_nxt = '0;
                    w_com_cnt_nxt = COMC_W'(1);
                    w_state_nxt   = COUNT;
                end
`endif
            end
            default: begin
                w_state_nxt = ALIGN;
            end
        endcase
    end

    assign data_out  = r_data;
    assign valid_out = r_valid;
    assign active    = r_active;

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Bench for serial_to_parallel_rx: scenario tasks checked against a position-based reference model.
`timescale 1ns/1ps
module tb_serial_to_parallel_rx;

    localparam logic [7:0] COM  = 8'hBC;
    localparam int         CC   = 4;
    localparam int         MAXN = 1024;
`ifdef RX_LOSS_DET_EN
    localparam bit LOSS = 1'b1;
`else
    localparam bit LOSS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    int n_cmp = 0;
    int n_err = 0;
    int nb = 0;

    bit         q_bits[$];
    logic [7:0] exp_d[MAXN];
    logic       exp_v[MAXN];
    logic       exp_a[MAXN];
    logic [7:0] obs_d[MAXN];
    logic       obs_v[MAXN];
    logic       obs_a[MAXN];

    serial_to_parallel_rx #(.COM(COM), .COM_COUNT(CC)) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active)
    );

    always #5 clk = ~clk;

    // Byte formed by the 8 most recent bits up to and including stream index e
    function automatic logic [7:0] window(int e);
        logic [7:0] w;
        w = 8'h00;
        for (int i = 7; i >= 0; i--)
            w = {w[6:0], (e - i >= 0) ? logic'(q_bits[e - i]) : 1'b0};
        return w;
    endfunction

    // Reference: lock is tracked by the stream index of the anchoring COM; byte ends sit at anchor+8k
    function automatic void build_model();
        int         mode;
        int         anchor;
        int         cnt;
        logic [7:0] dout;
        logic [7:0] w;
        logic       v;
        bit         onb;
        mode = 0; anchor = -1; cnt = 0; dout = 8'h00;
        for (int e = 0; e < int'(q_bits.size()); e++) begin
            w   = window(e);
            v   = 1'b0;
            onb = (anchor >= 0) && (e > anchor) && (((e - anchor) % 8) == 0);
            if (mode == 0) begin
                if (w == COM) begin anchor = e; cnt = 1; mode = (cnt >= CC) ? 2 : 1; end
            end else if (mode == 1) begin
                if (onb) begin
                    if (w == COM) begin cnt++; if (cnt >= CC) mode = 2; end
                    else begin mode = 0; anchor = -1; cnt = 0; end
                end
            end else begin
                if (onb) begin dout = w; v = (w != COM); end
                else if (LOSS && w == COM) begin anchor = e; cnt = 1; mode = 1; end
            end
            exp_d[e] = dout; exp_v[e] = v; exp_a[e] = (mode == 2);
        end
    endfunction

    task automatic do_reset();
        data_in = 1'b0;
        reset_L = 1'b0;
        q_bits.delete();
        repeat (2) @(posedge clk);
        #2 reset_L = 1'b1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) q_bits.push_back(b[i]);
    endtask

    task automatic play();
        nb = q_bits.size();
        build_model();
        for (int e = 0; e < nb; e++) begin
            data_in = q_bits[e];
            @(posedge clk);
            #1;
            obs_d[e] = data_out; obs_v[e] = valid_out; obs_a[e] = active;
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++;
        if ({active, valid_out, data_out} !== 10'b0) begin
            n_err++; $display("FAIL reset_init got a=%b v=%b d=%h exp 0 0 00", active, valid_out, data_out);
        end
        for (int i = 0; i < CC; i++) push_byte(COM);
        push_byte(8'hA5);
        play();
        for (int e = 0; e < nb; e++) begin
            n_cmp++;
            if ({obs_a[e], obs_v[e], obs_d[e]} !== {exp_a[e], exp_v[e], exp_d[e]}) begin
                n_err++;
                $display("FAIL reset_model cyc=%0d got a=%b v=%b d=%h exp a=%b v=%b d=%h",
                         e, obs_a[e], obs_v[e], obs_d[e], exp_a[e], exp_v[e], exp_d[e]);
            end
        end
        n_cmp++;
        if ({active, data_out} !== {1'b1, 8'hA5}) begin
            n_err++; $display("FAIL reset_pre got a=%b d=%h exp a=1 d=a5", active, data_out);
        end
        data_in = 1'b1;
        @(posedge clk);
        #3 reset_L = 1'b0;
        #1;
        n_cmp++;
        if ({active, valid_out, data_out} !== 10'b0) begin
            n_err++; $display("FAIL reset_async got a=%b v=%b d=%h exp 0 0 00", active, valid_out, data_out);
        end
    endtask

    task automatic test_lock();
        int first_a;
        int pe[$];
        do_reset();
        repeat (3) q_bits.push_back(1'b0);
        for (int i = 0; i < CC; i++) push_byte(COM);
        push_byte(8'h5A);
        push_byte(8'hC3);
        play();
        first_a = -1;
        for (int e = 0; e < nb; e++) begin
            n_cmp++;
            if ({obs_a[e], obs_v[e], obs_d[e]} !== {exp_a[e], exp_v[e], exp_d[e]}) begin
                n_err++;
                $display("FAIL lock_model cyc=%0d got a=%b v=%b d=%h exp a=%b v=%b d=%h",
                         e, obs_a[e], obs_v[e], obs_d[e], exp_a[e], exp_v[e], exp_d[e]);
            end
            if (obs_a[e] === 1'b1 && first_a < 0) first_a = e;
            if (obs_v[e] === 1'b1) pe.push_back(e);
        end
        n_cmp++;
        if (first_a != 34) begin n_err++; $display("FAIL lock_latency got %0d exp 34", first_a); end
        n_cmp++;
        if (pe.size() != 2) begin n_err++; $display("FAIL lock_pulses got %0d exp 2", pe.size()); end
        else begin
            n_cmp++;
            if (pe[0] != 42 || pe[1] != 50 || obs_d[pe[0]] !== 8'h5A || obs_d[pe[1]] !== 8'hC3) begin
                n_err++;
                $display("FAIL lock_bytes got %0d:%h %0d:%h exp 42:5a 50:c3", pe[0], obs_d[pe[0]], pe[1], obs_d[pe[1]]);
            end
        end
    endtask

    task automatic test_broken();
        int first_a;
        int pe[$];
        do_reset();
        push_byte(COM); push_byte(COM); push_byte(8'h11);
        for (int i = 0; i < CC; i++) push_byte(COM);
        push_byte(8'h7E);
        play();
        first_a = -1;
        for (int e = 0; e < nb; e++) begin
            n_cmp++;
            if ({obs_a[e], obs_v[e], obs_d[e]} !== {exp_a[e], exp_v[e], exp_d[e]}) begin
                n_err++;
                $display("FAIL broken_model cyc=%0d got a=%b v=%b d=%h exp a=%b v=%b d=%h",
                         e, obs_a[e], obs_v[e], obs_d[e], exp_a[e], exp_v[e], exp_d[e]);
            end
            if (obs_a[e] === 1'b1 && first_a < 0) first_a = e;
            if (obs_v[e] === 1'b1) pe.push_back(e);
        end
        n_cmp++;
        if (first_a != 55) begin n_err++; $display("FAIL broken_latency got %0d exp 55", first_a); end
        n_cmp++;
        if (pe.size() != 1) begin n_err++; $display("FAIL broken_pulses got %0d exp 1", pe.size()); end
        else begin
            n_cmp++;
            if (pe[0] != 63 || obs_d[63] !== 8'h7E) begin
                n_err++; $display("FAIL broken_byte got %0d:%h exp 63:7e", pe[0], obs_d[pe[0]]);
            end
        end
    endtask

    task automatic test_idle();
        int pe[$];
        int drops;
        do_reset();
        for (int i = 0; i < CC; i++) push_byte(COM);
        push_byte(COM); push_byte(8'h00); push_byte(COM); push_byte(8'hFF);
        play();
        drops = 0;
        for (int e = 0; e < nb; e++) begin
            n_cmp++;
            if ({obs_a[e], obs_v[e], obs_d[e]} !== {exp_a[e], exp_v[e], exp_d[e]}) begin
                n_err++;
                $display("FAIL idle_model cyc=%0d got a=%b v=%b d=%h exp a=%b v=%b d=%h",
                         e, obs_a[e], obs_v[e], obs_d[e], exp_a[e], exp_v[e], exp_d[e]);
            end
            if (e >= 31 && obs_a[e] !== 1'b1) drops++;
            if (obs_v[e] === 1'b1) pe.push_back(e);
        end
        n_cmp++;
        if (drops != 0) begin n_err++; $display("FAIL idle_active got %0d inactive cycles exp 0", drops); end
        n_cmp++;
        if (pe.size() != 2) begin n_err++; $display("FAIL idle_pulses got %0d exp 2", pe.size()); end
        else begin
            n_cmp++;
            if (pe[0] != 47 || pe[1] != 63 || obs_d[47] !== 8'h00 || obs_d[63] !== 8'hFF) begin
                n_err++; $display("FAIL idle_bytes got %0d:%h %0d:%h exp 47:00 63:ff", pe[0], obs_d[pe[0]], pe[1], obs_d[pe[1]]);
            end
        end
        n_cmp++;
        if ({obs_v[55], obs_d[55]} !== {1'b0, COM}) begin
            n_err++; $display("FAIL idle_com got v=%b d=%h exp v=0 d=bc", obs_v[55], obs_d[55]);
        end
    endtask

    task automatic test_offset();
        int first_a;
        logic [7:0] b;
        do_reset();
        q_bits.push_back(1'b1); q_bits.push_back(1'b0); q_bits.push_back(1'b1);
        q_bits.push_back(1'b1); q_bits.push_back(1'b0);
        for (int i = 0; i < CC; i++) push_byte(COM);
        for (int i = 0; i < 6; i++) begin
            do b = 8'($urandom_range(0, 255)); while (b == COM);
            push_byte(b);
        end
        play();
        first_a = -1;
        for (int e = 0; e < nb; e++) begin
            n_cmp++;
            if ({obs_a[e], obs_v[e], obs_d[e]} !== {exp_a[e], exp_v[e], exp_d[e]}) begin
                n_err++;
                $display("FAIL offset_model cyc=%0d got a=%b v=%b d=%h exp a=%b v=%b d=%h",
                         e, obs_a[e], obs_v[e], obs_d[e], exp_a[e], exp_v[e], exp_d[e]);
            end
            if (obs_a[e] === 1'b1 && first_a < 0) first_a = e;
        end
        n_cmp++;
        if (first_a != 36) begin n_err++; $display("FAIL offset_latency got %0d exp 36", first_a); end
    endtask

    task automatic test_slip();
        do_reset();
        for (int i = 0; i < CC; i++) push_byte(COM);
        push_byte(8'h5A);
        repeat (4) q_bits.push_back(1'b0);
        for (int i = 0; i < CC; i++) push_byte(COM);
        push_byte(8'h3C);
        play();
        for (int e = 0; e < nb; e++) begin
            n_cmp++;
            if ({obs_a[e], obs_v[e], obs_d[e]} !== {exp_a[e], exp_v[e], exp_d[e]}) begin
                n_err++;
                $display("FAIL slip_model cyc=%0d got a=%b v=%b d=%h exp a=%b v=%b d=%h",
                         e, obs_a[e], obs_v[e], obs_d[e], exp_a[e], exp_v[e], exp_d[e]);
            end
        end
        n_cmp++;
        if ({obs_a[50], obs_a[51], obs_a[74], obs_a[75]} !== {1'b1, !LOSS, !LOSS, 1'b1}) begin
            n_err++;
            $display("FAIL slip_lock got a50=%b a51=%b a74=%b a75=%b exp 1 %b %b 1",
                     obs_a[50], obs_a[51], obs_a[74], obs_a[75], !LOSS, !LOSS);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            do_reset();
            repeat ($urandom_range(0, 7)) q_bits.push_back(1'($urandom_range(0, 1)));
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(0, 1) == 0) push_byte(COM);
                else push_byte(8'($urandom_range(0, 255)));
                if ($urandom_range(0, 7) == 0)
                    repeat ($urandom_range(1, 7)) q_bits.push_back(1'($urandom_range(0, 1)));
            end
            play();
            for (int e = 0; e < nb; e++) begin
                n_cmp++;
                if ({obs_a[e], obs_v[e], obs_d[e]} !== {exp_a[e], exp_v[e], exp_d[e]}) begin
                    n_err++;
                    $display("FAIL random_model it=%0d cyc=%0d got a=%b v=%b d=%h exp a=%b v=%b d=%h",
                             it, e, obs_a[e], obs_v[e], obs_d[e], exp_a[e], exp_v[e], exp_d[e]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_broken();
        test_idle();
        test_offset();
        test_slip();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
